timer_entry_countdown: RTL
==========================

TIMER_ENTRY_COUNTDOWN -- requirements
Module: timer_entry_countdown

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD display digits (legal 3..6).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples needed to accept a key (legal 1..255).
REQ-003 SHALL have parameter TICK_DIV, default 100000000, clock cycles per countdown second (legal >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port switches  input  10  digit keys; bit i pressed means digit i.
REQ-007 SHALL have port start  input  1  level, synchronous start/resume request.
REQ-008 SHALL have port cancel  input  1  level, synchronous pause/clear request.
REQ-009 SHALL have port digits  output  4*NUM_DIGITS  BCD digits: [3:0] units of seconds, [7:4] tens of seconds, [11:8] units of minutes, then higher minute digits.
REQ-010 SHALL have port key_code  output  4  last accepted digit.
REQ-011 SHALL have port key_valid  output  1  one-cycle pulse on each accepted key.
REQ-012 SHALL have ports running, paused, alarm  output  1 each  state flags.

Function
REQ-013 SHALL implement states IDLE, ENTRY, RUN, PAUSE, DONE; running=1 only in RUN, paused=1 only in PAUSE, alarm=1 only in DONE.
REQ-014 SHALL encode switches by lowest set index (e.g. 10'b0000100100 -> 2); all-zero means no key.
REQ-015 SHALL accept a key on the edge where switches has been nonzero and identical for DEBOUNCE_CYCLES consecutive sampled edges; any change restarts the count.
REQ-016 SHALL accept at most one key per press; re-arm only after switches sampled all-zero for one cycle.
REQ-017 SHALL, on an accepted key in IDLE or ENTRY, shift digits up one position, insert the key at digits[3:0], discard the top digit, update key_code, pulse key_valid, and go to ENTRY.
REQ-018 SHALL ignore (not accept, no key_valid) keys in RUN, PAUSE and DONE; debounce still tracks and re-arms.
REQ-019 SHALL not range-check the tens-of-seconds digit at entry (values 6..9 permitted, e.g. 0:75).
REQ-020 SHALL, in ENTRY with start=1 and digits nonzero, go to RUN; start with all-zero digits is ignored.
REQ-021 SHALL hold a tick counter at 0 outside RUN, count 0..TICK_DIV-1 in RUN, and decrement digits once on the edge where it equals TICK_DIV-1 (first decrement TICK_DIV cycles after entering RUN).
REQ-022 SHALL decrement as BCD: seconds pair decrements normally; when seconds pair is 00, it becomes 59 and the minute digits borrow as a BCD decimal number.
REQ-023 SHALL, on the decrement reaching all-zero digits, go to DONE in the same edge.
REQ-024 SHALL, in RUN with cancel=1, go to PAUSE holding digits; in PAUSE start=1 returns to RUN with tick counter restarted at 0.
REQ-025 SHALL, in ENTRY or PAUSE with cancel=1, clear digits to 0 and go to IDLE.
REQ-026 SHALL, in DONE, hold alarm until start=1 or cancel=1, then go to IDLE with digits 0.
REQ-027 SHALL give cancel priority over start when both are 1; start over an accepted key in the same cycle (key dropped, no key_valid).

Reset
REQ-028 SHALL, while rst=0, force state IDLE, digits 0, key_code 0, key_valid 0, running/paused/alarm 0, tick and debounce counters 0, key path armed.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst returns to 1, including when reset was asserted mid-RUN or mid-debounce.

Verification (NUM_DIGITS=4, DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-030 SHALL cover: rst=0 mid-countdown -> digits=16'h0000, running=0, alarm=0 immediately, without a clock edge.
REQ-031 SHALL cover: press bit1, release, bit3, release, bit0, each held 6 cycles -> digits=16'h0130, three key_valid pulses, key_code=0.
REQ-032 SHALL cover: bit5 held 3 cycles then released -> no key_valid, digits unchanged; bit5 held 20 cycles -> exactly one key_valid.
REQ-033 SHALL cover: enter 5, start -> digits reaches 16'h0000 and alarm=1 exactly 50 cycles after RUN entry; start -> IDLE.
REQ-034 SHALL cover: enter 1,0,0 (1:00), start -> digits=16'h0059 after 10 cycles; enter 9,9 -> counts 0099, 0098.
REQ-035 SHALL cover: cancel during RUN -> paused=1, digits held; start -> resumes; cancel+start together in PAUSE -> IDLE, digits 0.

Source files
------------

// File: rtl/timer_entry_countdown.sv
// Keypad-entered BCD countdown timer (MM..:SS) with debounced digit keys,
// start/pause/cancel control and an alarm state when the count reaches zero.
`timescale 1ns/1ps
module timer_entry_countdown #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 100000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              switches,
  input  logic                    start,
  input  logic                    cancel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              key_code,
  output logic                    key_valid,
  output logic                    running,
  output logic                    paused,
  output logic                    alarm
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic [DW-1:0] digits_next, dec_value;
  logic [TW-1:0] tick, tick_next;
  logic [9:0]    last_sw;
  logic [7:0]    deb_cnt, deb_cnt_next;
  logic          armed, fire, key_take, borrow;
  logic [3:0]    key;

  always_comb begin
    key = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (switches[9-i]) key = 4'(9-i);
    end
  end

  // Run length of identical nonzero samples, saturating at the threshold.
  always_comb begin
    deb_cnt_next = '0;
    if (switches != '0) begin
      if (switches == last_sw)
        deb_cnt_next = (deb_cnt == 8'(DEBOUNCE_CYCLES)) ? deb_cnt : deb_cnt + 8'd1;
      else
        deb_cnt_next = 8'd1;
    end
    fire = armed && (deb_cnt_next == 8'(DEBOUNCE_CYCLES));
  end

  always_comb begin
    dec_value = digits;
    borrow    = 1'b0;
    if (digits[3:0] != 4'd0) begin
      dec_value[3:0] = digits[3:0] - 4'd1;
    end else if (digits[7:4] != 4'd0) begin
      dec_value[7:4] = digits[7:4] - 4'd1;
      dec_value[3:0] = 4'd9;
    end else begin
      dec_value[7:0] = 8'h59;
      borrow         = 1'b1;
      for (int unsigned i = 2; i < NUM_DIGITS; i++) begin
        if (borrow) begin
          if (digits[4*i +: 4] == 4'd0) begin
            dec_value[4*i +: 4] = 4'd9;
          end else begin
            dec_value[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            borrow              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    digits_next = digits;
    tick_next   = '0;
    key_take    = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (cancel) begin
          state_next  = IDLE;
          digits_next = '0;
        end else if (start) begin
          if (state == ENTRY && digits != '0) state_next = RUN;
        end else if (fire) begin
          key_take    = 1'b1;
          digits_next = {digits[DW-5:0], key};
          state_next  = ENTRY;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = PAUSE;
        end else if (tick == TW'(TICK_DIV-1)) begin
          digits_next = dec_value;
          if (dec_value == '0) state_next = DONE;
        end else begin
          tick_next = tick + TW'(1);
        end
      end
      PAUSE: begin
        if (cancel) begin
          state_next  = IDLE;
          digits_next = '0;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (cancel || start) begin
          state_next  = IDLE;
          digits_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        digits_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      digits    <= '0;
      tick      <= '0;
      last_sw   <= '0;
      deb_cnt   <= '0;
      armed     <= 1'b1;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      digits    <= digits_next;
      tick      <= tick_next;
      last_sw   <= switches;
      deb_cnt   <= deb_cnt_next;
      // A fired press is consumed even when the state ignores keys.
      if (switches == '0) armed <= 1'b1;
      else if (fire)      armed <= 1'b0;
      key_valid <= key_take;
      if (key_take) key_code <= key;
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign alarm   = (state == DONE);
endmodule
